// File: rtl/dct_muladd_pipe.sv
// dct_muladd_pipe: pipelined signed dot product with round-half-up and saturation.
// Ports: clk/reset, in_valid/in_ready/data_in/coeff in, out_valid/out_ready/data_out/out_sat out.
module dct_muladd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8,
  parameter int FRAC_BITS  = 12,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] coeff,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_WIDTH-1:0]             data_out,
  output logic                             out_sat
);

  localparam int LVLS = $clog2(DATA_DEPTH);
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int SW   = PW + LVLS;
  localparam int RW   = SW + 1;

  logic                  w_en;
  logic [LVLS:0]         r_vld;
  logic                  r_out_valid;
  logic [OUT_WIDTH-1:0]  r_data;
  logic                  r_sat;

  logic signed [PW-1:0]  w_a    [DATA_DEPTH];
  logic signed [PW-1:0]  w_b    [DATA_DEPTH];
  logic signed [PW-1:0]  w_prod [DATA_DEPTH];

  // Level 0 holds products, level l holds DATA_DEPTH>>l partial sums.
  logic signed [SW-1:0]  r_tree [LVLS+1][DATA_DEPTH];

  logic signed [RW-1:0]  w_full;
  logic signed [RW-1:0]  w_rnd;
  logic [OUT_WIDTH-1:0]  w_res;
  logic                  w_sat;

  // Global stall: every stage advances only when the output slot frees up.
  assign w_en      = !r_out_valid || out_ready;
  assign in_ready  = w_en && !reset;
  assign out_valid = r_out_valid;
  assign data_out  = r_data;
  assign out_sat   = r_sat;

  always_comb begin
    for (int i = 0; i < DATA_DEPTH; i++) begin
      w_a[i] = PW'($signed(
        data_in[i*DATA_WIDTH +: DATA_WIDTH]));
      w_b[i] = PW'($signed(
        coeff[i*DATA_WIDTH +: DATA_WIDTH]));
      w_prod[i] = w_a[i] * w_b[i];
    end
  end

  // Data path carries no reset; bubbles may
  // scribble here because the valid bits
  // gate what reaches data_out.
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < DATA_DEPTH; i++) begin
        r_tree[0][i] <= SW'(w_prod[i]);
      end
      for (int l = 1; l <= LVLS; l++) begin
        for (int i = 0; i < (DATA_DEPTH >> l); i++) begin
          r_tree[l][i] <= r_tree[l-1][2*i]
                        + r_tree[l-1][2*i+1];
        end
      end
    end
  end

  // One spare bit so the rounding constant
  // can never wrap the full-width sum.
  assign w_full = RW'(r_tree[LVLS][0]);

  generate
    if (FRAC_BITS > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF =
        RW'(1) <<< (FRAC_BITS - 1);
      assign w_rnd = (w_full + HALF) >>> FRAC_BITS;
    end else begin : g_nornd
      assign w_rnd = w_full;
    end
  endgenerate

  generate
    if (OUT_WIDTH < RW) begin : g_sat
      localparam logic signed [RW-1:0] MAXV =
        (RW'(1) <<< (OUT_WIDTH - 1)) - RW'(1);
      localparam logic signed [RW-1:0] MINV =
        -(RW'(1) <<< (OUT_WIDTH - 1));
      logic w_hi;
      logic w_lo;
      assign w_hi  = w_rnd > MAXV;
      assign w_lo  = w_rnd < MINV;
      assign w_sat = w_hi || w_lo;
      assign w_res = w_hi ? MAXV[OUT_WIDTH-1:0] :
                     w_lo ? MINV[OUT_WIDTH-1:0] :
                            w_rnd[OUT_WIDTH-1:0];
    end else begin : g_nosat
      assign w_sat = 1'b0;
      assign w_res = OUT_WIDTH'(w_rnd);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_sat       <= 1'b0;
    end else if (w_en) begin
      r_vld       <= {r_vld[LVLS-1:0], in_valid};
      r_out_valid <= r_vld[LVLS];
      // Hold the last result across bubbles.
      if (r_vld[LVLS]) begin
        r_data <= w_res;
        r_sat  <= w_sat;
      end
    end
  end

endmodule
